// File: rtl/pa_writeback_regfile_pkg.sv
// rtl/pa_writeback_regfile_pkg.sv - shared defaults for the writeback register file slice
package pa_writeback_regfile_pkg;

  // Default geometry: 32 registers of 16 bits, 4-entry writeback buffer.
  localparam int ADDR_W_DEF    = 5;
  localparam int DATA_W_DEF    = 16;
  localparam int BUF_DEPTH_DEF = 4;
  localparam int NUM_REGS_DEF  = 1 << ADDR_W_DEF;

  // Buffer entries are laid out as {addr, val}.
  localparam int ENTRY_W_DEF   = ADDR_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/pa_writeback_regfile_if.sv
// rtl/pa_writeback_regfile_if.sv - writeback, read and status bundle between pipes and regfile
interface pa_writeback_regfile_if
  import pa_writeback_regfile_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  localparam int CNT_W    = $clog2(BUF_DEPTH) + 1
);

  logic              wbA_i;
  logic [ADDR_W-1:0] wbAddrA_i;
  logic [DATA_W-1:0] wbValA_i;
  logic              wbB_i;
  logic [ADDR_W-1:0] wbAddrB_i;
  logic [DATA_W-1:0] wbValB_i;
  logic [ADDR_W-1:0] rdAddr0_i;
  logic [DATA_W-1:0] rdVal0_o;
  logic [ADDR_W-1:0] rdAddr1_i;
  logic [DATA_W-1:0] rdVal1_o;
  logic              stall_o;
  logic [CNT_W-1:0]  pending_o;
  logic              overflow_o;

  modport master (
    output wbA_i, wbAddrA_i, wbValA_i,
    output wbB_i, wbAddrB_i, wbValB_i,
    output rdAddr0_i, rdAddr1_i,
    input  rdVal0_o, rdVal1_o, stall_o, pending_o, overflow_o
  );

  modport slave (
    input  wbA_i, wbAddrA_i, wbValA_i,
    input  wbB_i, wbAddrB_i, wbValB_i,
    input  rdAddr0_i, rdAddr1_i,
    output rdVal0_o, rdVal1_o, stall_o, pending_o, overflow_o
  );

endinterface

// File: rtl/pa_writeback_regfile_wb_fifo.sv
// rtl/pa_writeback_regfile_wb_fifo.sv - 2-push/1-pop writeback buffer with youngest-match lookups
module pa_wb_fifo
  import pa_writeback_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push0,
  input  logic [ADDR_W-1:0] push0_addr,
  input  logic [DATA_W-1:0] push0_val,
  input  logic              push1,
  input  logic [ADDR_W-1:0] push1_addr,
  input  logic [DATA_W-1:0] push1_val,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_val,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] lk0_addr,
  output logic              lk0_hit,
  output logic [DATA_W-1:0] lk0_val,
  input  logic [ADDR_W-1:0] lk1_addr,
  output logic              lk1_hit,
  output logic [DATA_W-1:0] lk1_val
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] val_mem  [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tail1;

  // push1 lands right behind push0 when both are present, else at the tail itself
  assign tail1 = tail + PTR_W'(push0);

  // Entry storage; contents need no reset because count gates every use
  always_ff @(posedge clk) begin
    if (push0) begin
      addr_mem[tail] <= push0_addr;
      val_mem[tail]  <= push0_val;
    end
    if (push1) begin
      addr_mem[tail1] <= push1_addr;
      val_mem[tail1]  <= push1_val;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(push0) + PTR_W'(push1);
      count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  assign head_addr = addr_mem[head];
  assign head_val  = val_mem[head];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  // Walk oldest to youngest so the last live match (the youngest) wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    lk0_hit = 1'b0;
    lk0_val = '0;
    lk1_hit = 1'b0;
    lk1_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (addr_mem[idx] == lk0_addr) begin
          lk0_hit = 1'b1;
          lk0_val = val_mem[idx];
        end
        if (addr_mem[idx] == lk1_addr) begin
          lk1_hit = 1'b1;
          lk1_val = val_mem[idx];
        end
      end
    end
  end

endmodule

// File: rtl/pa_writeback_regfile.sv
// rtl/pa_writeback_regfile.sv - dual-writeback register file with one write port and collision buffer
module pa_writeback_regfile
  import pa_writeback_regfile_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  localparam int NUM_REGS = 1 << ADDR_W,
  localparam int CNT_W    = $clog2(BUF_DEPTH) + 1
) (
  input logic                    clock_i,
  input logic                    reset_i,
  pa_writeback_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              stall_q;
  logic              stall_d;
  logic              overflow_q;
  logic              accept;
  logic              a_take;
  logic              b_take;

  logic              commit_en;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_val;
  logic              pop;
  logic              push0;
  logic [ADDR_W-1:0] push0_addr;
  logic [DATA_W-1:0] push0_val;
  logic              push1;
  logic [ADDR_W-1:0] push1_addr;
  logic [DATA_W-1:0] push1_val;
  logic [CNT_W-1:0]  count_next;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_val;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              lk0_hit;
  logic [DATA_W-1:0] lk0_val;
  logic              lk1_hit;
  logic [DATA_W-1:0] lk1_val;

  // While stalled nothing is taken. A full buffer always implies stall, so the
  // full term only guards against ever writing over a live entry.
  assign accept = !stall_q && !fifo_full;
  // A same-address pair collapses to B: A would be overwritten anyway
  assign a_take = bus.wbA_i && accept &&
                  !(bus.wbB_i && (bus.wbAddrA_i == bus.wbAddrB_i));
  assign b_take = bus.wbB_i && accept;

  // Intake merge: the buffer head owns the write port when present, otherwise the
  // oldest incoming request writes directly; everything else queues in age order
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = '0;
    commit_val  = '0;
    pop         = 1'b0;
    push0       = 1'b0;
    push0_addr  = '0;
    push0_val   = '0;
    push1       = 1'b0;
    push1_addr  = '0;
    push1_val   = '0;
    if (!fifo_empty) begin
      commit_en   = 1'b1;
      commit_addr = head_addr;
      commit_val  = head_val;
      pop         = 1'b1;
      if (a_take) begin
        push0      = 1'b1;
        push0_addr = bus.wbAddrA_i;
        push0_val  = bus.wbValA_i;
        push1      = b_take;
        push1_addr = bus.wbAddrB_i;
        push1_val  = bus.wbValB_i;
      end else if (b_take) begin
        push0      = 1'b1;
        push0_addr = bus.wbAddrB_i;
        push0_val  = bus.wbValB_i;
      end
    end else if (a_take) begin
      commit_en   = 1'b1;
      commit_addr = bus.wbAddrA_i;
      commit_val  = bus.wbValA_i;
      push0       = b_take;
      push0_addr  = bus.wbAddrB_i;
      push0_val   = bus.wbValB_i;
    end else if (b_take) begin
      commit_en   = 1'b1;
      commit_addr = bus.wbAddrB_i;
      commit_val  = bus.wbValB_i;
    end
  end

  // Stall whenever fewer than two slots will be free after this edge
  assign count_next = count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  assign stall_d    = (count_next > CNT_W'(BUF_DEPTH - 2));

  pa_wb_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk        (clock_i),
    .rst        (reset_i),
    .push0      (push0),
    .push0_addr (push0_addr),
    .push0_val  (push0_val),
    .push1      (push1),
    .push1_addr (push1_addr),
    .push1_val  (push1_val),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_val   (head_val),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .lk0_addr   (bus.rdAddr0_i),
    .lk0_hit    (lk0_hit),
    .lk0_val    (lk0_val),
    .lk1_addr   (bus.rdAddr1_i),
    .lk1_hit    (lk1_hit),
    .lk1_val    (lk1_val)
  );

  // Registered stall and sticky overflow for writebacks offered while stalled
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (stall_q && (bus.wbA_i || bus.wbB_i)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Single write port into the register array
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit_en) begin
      regs[commit_addr] <= commit_val;
    end
  end

  // Buffered (not yet committed) data shadows the array on reads
  assign bus.rdVal0_o   = lk0_hit ? lk0_val : regs[bus.rdAddr0_i];
  assign bus.rdVal1_o   = lk1_hit ? lk1_val : regs[bus.rdAddr1_i];
  assign bus.stall_o    = stall_q;
  assign bus.pending_o  = count;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_pa_writeback_regfile.sv
// tb/tb_pa_writeback_regfile.sv - scoreboard bench for pa_writeback_regfile
module tb_pa_writeback_regfile;
  import pa_writeback_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pa_writeback_regfile_if bus ();

  pa_writeback_regfile dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef enum int {K_RD0, K_RD1, K_STALL, K_PEND, K_OVF} kind_t;
  typedef struct {
    kind_t kind;
    int    exp;
    string name;
  } chk_t;

  chk_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_chk(input kind_t k, input int e, input string n);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = n;
    sb_q.push_back(c);
  endtask

  task automatic rd0(input int a, input int e, input string n);
    bus.rdAddr0_i = 5'(a);
    expect_chk(K_RD0, e, n);
  endtask

  task automatic rd1(input int a, input int e, input string n);
    bus.rdAddr1_i = 5'(a);
    expect_chk(K_RD1, e, n);
  endtask

  task automatic status(input int s, input int p, input int o, input string n);
    expect_chk(K_STALL, s, {n, "_stall"});
    expect_chk(K_PEND,  p, {n, "_pending"});
    expect_chk(K_OVF,   o, {n, "_overflow"});
  endtask

  task automatic wb(input logic av, input int aa, input int ad,
                    input logic bv, input int ba, input int bd);
    bus.wbA_i     = av;
    bus.wbAddrA_i = 5'(aa);
    bus.wbValA_i  = 16'(ad);
    bus.wbB_i     = bv;
    bus.wbAddrB_i = 5'(ba);
    bus.wbValB_i  = 16'(bd);
  endtask

  task automatic idle();
    wb(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: everything queued for this cycle is compared at the falling edge
  always @(negedge clk) begin
    chk_t c;
    int   act;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      case (c.kind)
        K_RD0:   act = int'(bus.rdVal0_o);
        K_RD1:   act = int'(bus.rdVal1_o);
        K_STALL: act = int'(bus.stall_o);
        K_PEND:  act = int'(bus.pending_o);
        default: act = int'(bus.overflow_o);
      endcase
      total++;
      if (act != c.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle();
    bus.rdAddr0_i = '0;
    bus.rdAddr1_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state, whole array reads zero
    status(0, 0, 0, "t1");
    for (int i = 0; i < 16; i++) begin
      rd0(2 * i, 0, "t1_rd0_zero");
      rd1(2 * i + 1, 0, "t1_rd1_zero");
      step();
    end

    // 2: single A writeback commits directly
    wb(1'b1, 3, 'h1234, 1'b0, 0, 0);
    step();
    idle();
    rd0(3, 'h1234, "t2_r3");
    expect_chk(K_PEND, 0, "t2_pending");
    step();

    // 3: A and B to different registers: A commits, B buffered and forwarded
    wb(1'b1, 4, 'hAAAA, 1'b1, 5, 'h5555);
    step();
    idle();
    rd0(4, 'hAAAA, "t3_r4");
    rd1(5, 'h5555, "t3_r5_fwd");
    expect_chk(K_PEND, 1, "t3_pending1");
    step();
    rd1(5, 'h5555, "t3_r5_committed");
    expect_chk(K_PEND, 0, "t3_pending0");
    step();

    // 4: A and B to the same register: only B lands
    wb(1'b1, 7, 'h1111, 1'b1, 7, 'h2222);
    rd0(7, 0, "t4_r7_no_same_cycle_fwd");
    step();
    idle();
    rd0(7, 'h2222, "t4_r7");
    expect_chk(K_PEND, 0, "t4_pending");
    step();
    rd0(7, 'h2222, "t4_r7_hold");
    step();

    // 5: three back-to-back dual writebacks fill the buffer, then it drains
    wb(1'b1, 8, 'h0801, 1'b1, 9, 'h0902);
    step();
    status(0, 1, 0, "t5_c1");
    wb(1'b1, 8, 'h0803, 1'b1, 10, 'h0A04);
    step();
    status(0, 2, 0, "t5_c2");
    wb(1'b1, 9, 'h0905, 1'b1, 8, 'h0806);
    step();
    idle();
    status(1, 3, 0, "t5_full");
    rd0(8, 'h0806, "t5_fwd_r8");
    rd1(9, 'h0905, "t5_fwd_r9");
    step();
    status(0, 2, 0, "t5_drain2");
    step();
    status(0, 1, 0, "t5_drain1");
    step();
    status(0, 0, 0, "t5_drain0");
    rd0(8, 'h0806, "t5_final_r8");
    rd1(9, 'h0905, "t5_final_r9");
    step();
    rd0(10, 'h0A04, "t5_final_r10");
    step();

    // 6: writeback during stall is dropped and flagged; reset with 3 pending
    wb(1'b1, 11, 'hB001, 1'b1, 12, 'hC001);
    step();
    wb(1'b1, 13, 'hD001, 1'b1, 14, 'hE001);
    step();
    wb(1'b1, 15, 'hF001, 1'b1, 16, 'h1601);
    step();
    wb(1'b1, 20, 'hDEAD, 1'b0, 0, 0);
    status(1, 3, 0, "t6_stalled");
    step();
    status(0, 2, 1, "t6_after_drop");
    rd0(20, 0, "t6_r20_dropped");
    wb(1'b1, 21, 'h2101, 1'b1, 22, 'h2202);
    step();
    idle();
    status(1, 3, 1, "t6_refill");
    rd0(22, 'h2202, "t6_fwd_r22");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    status(0, 0, 0, "t6_in_reset");
    rd0(16, 0, "t6_rst_r16");
    rd1(22, 0, "t6_rst_r22");
    step();
    rst = 1'b0;
    status(0, 0, 0, "t6_post_reset");
    rd0(21, 0, "t6_post_r21");
    rd1(22, 0, "t6_post_r22");
    step();
    rd0(16, 0, "t6_post_r16");
    rd1(7, 0, "t6_post_r7");
    step();

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
